// File: rtl/data_mem_resp_pkg.sv
// Shared types and defaults for the data-memory responder.
// Stall-injection LFSR helpers are used when DMEM_STALL_INJECT_EN is defined.
package data_mem_resp_pkg;

    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0001_0000;
    localparam int unsigned DMEM_DEPTH_WORDS = 4096;
    localparam logic [15:0] DMEM_LFSR_SEED   = 16'hACE1;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } dmem_resp_t;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous SRAM, 32-bit words, per-byte write enable, 1-cycle read.
module dmem_ram #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Contents deliberately not reset
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: decode, grant/outstanding control, fixed-latency in-order responses.
// Define DMEM_STALL_INJECT_EN to add LFSR-driven pseudo-random grant stalls.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR       = DMEM_BASE_ADDR,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_req,
    input  logic        data_wr,
    output logic        data_gnt,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        data_error
);

    localparam int unsigned AW    = $clog2(MEM_DEPTH_WORDS);
    localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * MEM_DEPTH_WORDS);

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_acc;
    logic          w_stall;
    logic          w_valid;
    logic          w_unused;
    logic [31:0]   w_ram_rdata;
    logic [CW-1:0] r_cnt;
    logic          r_s0_valid;
    logic          r_s0_err;
    logic          r_s0_load;
    dmem_resp_t    w_s0;
    dmem_resp_t    w_out;

    assign w_off      = data_addr - BASE_ADDR;
    assign w_idx      = w_off[AW+1:2];
    assign w_in_range = (data_addr >= BASE_ADDR) && (33'(data_addr) < LIMIT);
    assign w_unused   = ^{w_off[1:0], w_off[31:AW+2]};

`ifdef DMEM_STALL_INJECT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lfsr <= DMEM_LFSR_SEED;
        else          r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // A retiring response frees its slot in the same cycle
    assign data_gnt = data_req & ((r_cnt < CW'(MAX_OUTSTANDING)) | w_valid) & ~w_stall;
    assign w_acc    = data_req & data_gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_acc && !w_valid) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (!w_acc && w_valid) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    dmem_ram #(
        .DEPTH (MEM_DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_acc & w_in_range),
        .i_we    (data_wr),
        .i_be    (data_be),
        .i_addr  (w_idx),
        .i_wdata (data_wdata),
        .o_rdata (w_ram_rdata)
    );

    // First pipeline stage: control captured at the accept edge, data from the SRAM read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s0_valid <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_load  <= 1'b0;
        end else begin
            r_s0_valid <= w_acc;
            r_s0_err   <= w_acc & ~w_in_range;
            r_s0_load  <= w_acc & w_in_range & ~data_wr;
        end
    end

    always_comb begin
        w_s0       = '0;
        w_s0.valid = r_s0_valid;
        w_s0.err   = r_s0_err;
        if (r_s0_load) w_s0.rdata = w_ram_rdata;
    end

    generate
        if (RESP_LATENCY == 1) begin : g_lat1
            assign w_out = w_s0;
        end else begin : g_pipe
            dmem_resp_t r_pipe [RESP_LATENCY-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(RESP_LATENCY) - 1; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_s0;
                    for (int i = 1; i < int'(RESP_LATENCY) - 1; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign w_out = r_pipe[RESP_LATENCY-2];
        end
    endgenerate

    assign w_valid    = w_out.valid;
    assign data_valid = w_valid;
    assign data_error = w_valid & w_out.err;
    assign data_rdata = w_valid ? w_out.rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp (RESP_LATENCY=3, MAX_OUTSTANDING=2).
// Honours DMEM_STALL_INJECT_EN by predicting stall cycles from a reference LFSR.
module tb_data_mem_resp;

    localparam int unsigned LAT   = 3;
    localparam int unsigned MAXO  = 2;
    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic        data_gnt;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        data_error;

    data_mem_resp #(
        .MEM_DEPTH_WORDS (DEPTH),
        .BASE_ADDR       (BASE),
        .RESP_LATENCY    (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_gnt   (data_gnt),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_be    (data_be),
        .data_rdata (data_rdata),
        .data_valid (data_valid),
        .data_error (data_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] mem [DEPTH];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_mis = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR written as plain shift arithmetic
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= (m_lfsr >> 1) | 16'(((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h1) << 15);
    end

    function automatic bit model_stall();
`ifdef DMEM_STALL_INJECT_EN
        return (m_lfsr % 4) == 0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference behaviour of one accepted request
    task automatic model_accept(input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
        exp_t    e;
        longint  a;
        int      idx;
        bit      inr;
        a       = longint'(addr);
        inr     = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * longint'(DEPTH));
        e.cyc   = cyc + int'(LAT);
        e.err   = !inr;
        e.rdata = 32'h0;
        if (inr) begin
            idx = int'((a - longint'(BASE)) / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                e.rdata = mem[idx];
            end
        end
        q.push_back(e);
    endtask

    task automatic step(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, output bit acc);
        bit exp_g;
        @(negedge clk);
        #1;
        data_req   = req;
        data_wr    = wr;
        data_addr  = addr;
        data_wdata = wdata;
        data_be    = be;
        #1;
        exp_g = req && (q.size() < int'(MAXO)) && !model_stall();
        n_vec++;
        if (data_gnt !== exp_g) begin
            n_mis++;
            $display("FAIL gnt cyc=%0d got %b want %b (pending %0d)", cyc, data_gnt, exp_g, q.size());
        end
        acc = req && (data_gnt === 1'b1);
        if (acc) model_accept(wr, addr, wdata, be);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, wr, addr, wdata, be, acc);
            n++;
        end while (!acc && n < 50);
        n_vec++;
        if (!acc) begin
            n_mis++;
            $display("FAIL grant_timeout addr=%h got no grant want grant within 50 cycles", addr);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
    endtask

    // Monitor: pops and compares whenever the DUT presents a response
    always @(negedge clk) begin
        if (reset_n) begin
            if (data_valid) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_valid cyc=%0d got rdata=%h err=%b want no response", cyc, data_rdata, data_error);
                end else begin
                    mon_e = q.pop_front();
                    if (data_rdata !== mon_e.rdata || data_error !== mon_e.err || cyc != mon_e.cyc) begin
                        n_mis++;
                        $display("FAIL resp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                                 data_rdata, data_error, cyc, mon_e.rdata, mon_e.err, mon_e.cyc);
                    end
                end
            end else begin
                n_vec++;
                if (data_rdata !== 32'h0 || data_error !== 1'b0) begin
                    n_mis++;
                    $display("FAIL idle_outputs cyc=%0d got rdata=%h err=%b want 0/0", cyc, data_rdata, data_error);
                end
                if (q.size() > 0) begin
                    n_vec++;
                    if (q[0].cyc <= cyc) begin
                        n_mis++;
                        $display("FAIL missing_resp cyc=%0d got no valid want response due cyc %0d", cyc, q[0].cyc);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] oor [5];
        logic [31:0] addr;
        int          r;
        int          n_rand;
        bit          acc;
        oor[0] = 32'h0000_FFFC;
        oor[1] = 32'h0001_4000;
        oor[2] = 32'h0000_0000;
        oor[3] = 32'hFFFF_FFFC;
        oor[4] = 32'h0001_4010;

        // Reset state: grant reflects request with an empty counter
        data_req = 1'b1;
        #12;
        n_vec++;
        if (data_gnt !== 1'b1 || data_valid !== 1'b0 || data_rdata !== 32'h0 || data_error !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_state got gnt=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                     data_gnt, data_valid, data_rdata, data_error);
        end
        data_req = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Full-word store then load
        issue(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, 32'h0001_0010, 32'h0, 4'hF);
        // Byte-lane store merge
        issue(1'b1, 32'h0001_0020, 32'h1122_3344, 4'hF);
        issue(1'b1, 32'h0001_0020, 32'h00AA_0000, 4'b0100);
        issue(1'b0, 32'h0001_0022, 32'h0, 4'h0);
        // Zero byte-enable store is a no-op
        issue(1'b1, 32'h0001_0020, 32'hFFFF_FFFF, 4'h0);
        issue(1'b0, 32'h0001_0020, 32'h0, 4'h0);
        // Boundaries: top word in range, both ends just outside, aliasing store ignored
        issue(1'b1, 32'h0001_3FFC, 32'hCAFE_F00D, 4'hF);
        issue(1'b0, 32'h0001_3FFC, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_FFFC, 32'h0, 4'h0);
        issue(1'b0, 32'h0001_4000, 32'h0, 4'h0);
        issue(1'b1, 32'h0001_4010, 32'h0BAD_0BAD, 4'hF);
        issue(1'b0, 32'h0001_0010, 32'h0, 4'h0);

        // Request held high: grant throttled by the outstanding limit
        idle(int'(LAT) + 2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'h0, acc);
        idle(int'(LAT) + 2);

        // Reset pulse with two loads in flight
        issue(1'b0, 32'h0001_0010, 32'h0, 4'h0);
        issue(1'b0, 32'h0001_0020, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        reset_n  = 1'b0;
        data_req = 1'b0;
        q.delete();
        @(negedge clk);
        #1 reset_n = 1'b1;
        issue(1'b0, 32'h0001_0010, 32'h0, 4'h0);
        idle(int'(LAT) + 4);

        // Seed a small working set, then random traffic against the model
        for (int i = 0; i < 16; i++) begin
            r = (i < 15) ? i : int'(DEPTH) - 1;
            issue(1'b1, BASE + 32'(r * 4), $urandom, 4'hF);
        end
`ifdef DMEM_STALL_INJECT_EN
        n_rand = 1000;
`else
        n_rand = 600;
`endif
        for (int i = 0; i < n_rand; i++) begin
            r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) addr = oor[$urandom_range(0, 4)];
            else addr = BASE + 32'(((r < 15) ? r : int'(DEPTH) - 1) * 4) + 32'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr, $urandom,
                 4'($urandom_range(0, 15)), acc);
        end
        idle(int'(LAT) + 3);

        n_vec++;
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
